adder_result_checker: RTL and testbench
=======================================

// Module: adder_result_checker
// PURPOSE
//  Synthesizable self-checking stage downstream of the adder DUV and reference adder.
//  Each cycle it takes one vector: operands, DUV outputs and reference outputs.
//  It flags mismatches, counts vectors and failures, captures the first failing vector,
//  and declares pass/fail after NUM_VECTORS vectors.
//  It replaces the non-synthesizable comparator, so csa/cra/cla/a1csa benches can run on FPGA or emulation.
// PARAMETERS
//  n            64     operand width; must match the DUV
//  type         0      0 = compare s,cout (csa,cra,a1csa); 1 = also compare prop,gen (cla,a1csah)
//  NUM_VECTORS  30000  vectors per run; must be >= 1
//  CNT_W        32     width of the vector and fail counters
//  STOP_ON_FAIL 0      1 = halt the run on the first mismatch
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      one-cycle pulse; clears all results and begins a run
//  valid      in   1      the vector on the inputs below is valid this cycle
//  ready      out  1      checker accepts vectors (state RUN)
//  cin        in   1      carry-in applied to both adders
//  a, b       in   n      operands applied to both adders
//  s_ref      in   n      reference sum
//  cout_ref   in   1      reference carry-out
//  prop_ref   in   1      reference group propagate
//  gen_ref    in   1      reference group generate
//  s_duv      in   n      DUV sum
//  cout_duv   in   1      DUV carry-out
//  prop_duv   in   1      DUV group propagate
//  gen_duv    in   1      DUV group generate
//  vec_cnt    out  CNT_W  vectors checked in this run
//  fail_cnt   out  CNT_W  mismatching vectors; saturates at all-ones
//  err        out  1      sticky; set on the first mismatch of the run
//  ff_a, ff_b out  n      a, b of the first failing vector
//  ff_cin     out  1      cin of the first failing vector
//  ff_s_ref   out  n      s_ref of the first failing vector
//  ff_s_duv   out  n      s_duv of the first failing vector
//  done       out  1      run finished (state DONE or HALT)
//  pass       out  1      done && fail_cnt==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pipeline valid cleared.
//   All outputs 0: ready, vec_cnt, fail_cnt, err, done, pass, every ff_* bus.
//  FSM
//   IDLE -start-> RUN
//   RUN -(last vector retired)-> DONE
//   RUN -(mismatch retired && STOP_ON_FAIL)-> HALT
//   DONE/HALT -start-> RUN
//  Accept: a vector is taken when valid && ready. valid outside RUN is ignored; nothing is counted.
//  Stage 1 (edge k): register the accepted vector and mism.
//   mism = (s_ref!=s_duv) | (cout_ref!=cout_duv) | (type==1 & ((prop_ref!=prop_duv) | (gen_ref!=gen_duv)))
//  Stage 2 (edge k+1): retire the vector.
//   vec_cnt += 1.
//   If mism: fail_cnt += 1 (saturating), err <= 1.
//   If mism && fail_cnt==0: load every ff_* bus from the stage-1 registers.
//  Latency: counters and err update 2 edges after the vector is sampled.
//  End of run: ready drops on the edge that accepts vector NUM_VECTORS.
//   done rises on the edge that retires it.
//  Halt: with STOP_ON_FAIL=1, ready drops on the retire edge of the first mismatch.
//   Any vector already in stage 1 is discarded and not counted.
//  start in any state: counters, err and ff_* are cleared, stage 1 is flushed, state goes to RUN.
//   A valid on the same cycle as start is dropped (start wins).
//  Reset during a run: aborts immediately, all results are lost.
//  vec_cnt wrap cannot occur; requirement: NUM_VECTORS < 2**CNT_W.
// STRUCTURE
//  Shared package adder_tb_pkg:
//   FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2, HALT=2'd3.
//   type encodings TYPE_BASIC=0, TYPE_PG=1, shared with the comparator and logger.
//  Sub-module adder_mismatch_detect: combinational mism generation, parameterized on n and type.
//  Counters, capture registers and FSM stay in the top module.
// TESTING
//  1. Reset mid-RUN after 5 vectors -> on the next cycle all outputs are 0 and state is IDLE.
//  2. NUM_VECTORS=8, DUV == ref, valid held high -> vec_cnt=8, fail_cnt=0, done=1, pass=1.
//     done rises 2 edges after the 8th accept.
//  3. Vector 3 with s_duv = s_ref ^ 64'h1 -> fail_cnt=1, err=1, pass=0.
//     ff_a/ff_b/ff_cin/ff_s_* hold vector 3; a later fail on vector 6 leaves ff_* unchanged.
//  4. type=1, only gen_duv differs -> counted as a fail.
//     type=0, same stimulus -> counted as a pass.
//  5. STOP_ON_FAIL=1, fail on vector 2, valid continuous -> HALT with vec_cnt=2 and fail_cnt=1.
//     Vector 3, held in stage 1, is not counted.
//  6. start pulsed together with valid in DONE -> counters are 0, RUN is entered, that vector is not counted.
//     A subsequent 8-vector run passes.

Source files
------------

// File: rtl/adder_tb_pkg.sv
// rtl/adder_tb_pkg.sv - shared state and compare-type encodings for the adder checking stage
package adder_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int TYPE_BASIC = 0;
  localparam int TYPE_PG    = 1;

endpackage

// File: rtl/adder_mismatch_detect.sv
// rtl/adder_mismatch_detect.sv - combinational DUV vs reference comparison for one vector
module adder_mismatch_detect
  import adder_tb_pkg::*;
#(
  parameter int n        = 64,
  parameter int CMP_TYPE = TYPE_BASIC
) (
  input  logic [n-1:0] s_ref,
  input  logic         cout_ref,
  input  logic         prop_ref,
  input  logic         gen_ref,
  input  logic [n-1:0] s_duv,
  input  logic         cout_duv,
  input  logic         prop_duv,
  input  logic         gen_duv,
  output logic         mism
);

  logic pg_mism;

  // Group propagate/generate only exist on the lookahead-style adders.
  assign pg_mism = (CMP_TYPE == TYPE_PG) && ((prop_ref != prop_duv) || (gen_ref != gen_duv));
  assign mism    = (s_ref != s_duv) || (cout_ref != cout_duv) || pg_mism;

endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - two-stage synthesizable result checker for adder benches
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int n            = 64,
  parameter int CMP_TYPE     = TYPE_BASIC,
  parameter int NUM_VECTORS  = 30000,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  output logic             ready,
  input  logic             cin,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  input  logic [n-1:0]     s_ref,
  input  logic             cout_ref,
  input  logic             prop_ref,
  input  logic             gen_ref,
  input  logic [n-1:0]     s_duv,
  input  logic             cout_duv,
  input  logic             prop_duv,
  input  logic             gen_duv,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [n-1:0]     ff_a,
  output logic [n-1:0]     ff_b,
  output logic             ff_cin,
  output logic [n-1:0]     ff_s_ref,
  output logic [n-1:0]     ff_s_duv,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mism_q, s1_cin_q;
  logic [n-1:0]     s1_a_q, s1_b_q, s1_s_ref_q, s1_s_duv_q;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [n-1:0]     ff_a_q, ff_b_q, ff_s_ref_q, ff_s_duv_q;
  logic             ff_cin_q;
  logic             mism, accept, capture;

  adder_mismatch_detect #(
    .n        (n),
    .CMP_TYPE (CMP_TYPE)
  ) u_detect (
    .s_ref    (s_ref),
    .cout_ref (cout_ref),
    .prop_ref (prop_ref),
    .gen_ref  (gen_ref),
    .s_duv    (s_duv),
    .cout_duv (cout_duv),
    .prop_duv (prop_duv),
    .gen_duv  (gen_duv),
    .mism     (mism)
  );

  // acc_cnt tracks accepted vectors so ready drops on the edge taking the last one.
  assign ready  = (state_q == ST_RUN) && (acc_cnt_q != NUM_LAST);
  assign accept = valid && ready && !start;

  always_comb begin
    state_d    = state_q;
    s1_valid_d = accept;
    acc_cnt_d  = accept ? acc_cnt_q + CNT_ONE : acc_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    capture    = 1'b0;
    if (s1_valid_q) begin
      vec_cnt_d = vec_cnt_q + CNT_ONE;
      if (s1_mism_q) begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_ONE;
        err_d   = 1'b1;
        capture = (fail_cnt_q == '0);
      end
      if (s1_mism_q && (STOP_ON_FAIL != 0)) begin
        state_d    = ST_HALT;
        s1_valid_d = 1'b0;
      end else if (vec_cnt_d == NUM_LAST) begin
        state_d = ST_DONE;
      end
    end
    if (start) begin
      state_d    = ST_RUN;
      s1_valid_d = 1'b0;
      acc_cnt_d  = '0;
      vec_cnt_d  = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      acc_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      acc_cnt_q  <= acc_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mism_q  <= 1'b0;
      s1_cin_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_s_ref_q <= '0;
      s1_s_duv_q <= '0;
    end else if (accept) begin
      s1_mism_q  <= mism;
      s1_cin_q   <= cin;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_s_ref_q <= s_ref;
      s1_s_duv_q <= s_duv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_cin_q   <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_s_ref_q <= '0;
      ff_s_duv_q <= '0;
    end else if (start) begin
      ff_cin_q   <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_s_ref_q <= '0;
      ff_s_duv_q <= '0;
    end else if (capture) begin
      ff_cin_q   <= s1_cin_q;
      ff_a_q     <= s1_a_q;
      ff_b_q     <= s1_b_q;
      ff_s_ref_q <= s1_s_ref_q;
      ff_s_duv_q <= s1_s_duv_q;
    end
  end

  assign vec_cnt  = vec_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err      = err_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_cin   = ff_cin_q;
  assign ff_s_ref = ff_s_ref_q;
  assign ff_s_duv = ff_s_duv_q;
  assign done     = (state_q == ST_DONE) || (state_q == ST_HALT);
  assign pass     = done && (fail_cnt_q == '0);

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - directed self-checking bench for adder_result_checker
module tb_adder_result_checker;
  import adder_tb_pkg::*;

  // Instance 0: TYPE_PG; 1: TYPE_BASIC; 2: TYPE_PG with STOP_ON_FAIL.
  logic        clk, rst_n, start, valid, cin;
  logic [63:0] a, b, s_ref, s_duv;
  logic        cout_ref, prop_ref, gen_ref, cout_duv, prop_duv, gen_duv;

  logic        ready    [3];
  logic [31:0] vec_cnt  [3];
  logic [31:0] fail_cnt [3];
  logic        err      [3];
  logic [63:0] ff_a     [3];
  logic [63:0] ff_b     [3];
  logic        ff_cin   [3];
  logic [63:0] ff_s_ref [3];
  logic [63:0] ff_s_duv [3];
  logic        done     [3];
  logic        pass     [3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adder_result_checker #(
      .n            (64),
      .CMP_TYPE     ((g == 1) ? TYPE_BASIC : TYPE_PG),
      .NUM_VECTORS  (8),
      .CNT_W        (32),
      .STOP_ON_FAIL ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .valid    (valid),
      .ready    (ready[g]),
      .cin      (cin),
      .a        (a),
      .b        (b),
      .s_ref    (s_ref),
      .cout_ref (cout_ref),
      .prop_ref (prop_ref),
      .gen_ref  (gen_ref),
      .s_duv    (s_duv),
      .cout_duv (cout_duv),
      .prop_duv (prop_duv),
      .gen_duv  (gen_duv),
      .vec_cnt  (vec_cnt[g]),
      .fail_cnt (fail_cnt[g]),
      .err      (err[g]),
      .ff_a     (ff_a[g]),
      .ff_b     (ff_b[g]),
      .ff_cin   (ff_cin[g]),
      .ff_s_ref (ff_s_ref[g]),
      .ff_s_duv (ff_s_duv[g]),
      .done     (done[g]),
      .pass     (pass[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec_a(input int i);
    return {32'hDEAD_0000 | 32'(i), 32'h8000_0000 + 32'(i) * 32'h1111};
  endfunction

  function automatic logic [63:0] vec_b(input int i);
    return ~vec_a(i) ^ 64'(i);
  endfunction

  function automatic logic vec_cin(input int i);
    return (i % 2) == 1;
  endfunction

  function automatic logic [64:0] vec_sum(input int i);
    return {1'b0, vec_a(i)} + {1'b0, vec_b(i)} + {64'd0, vec_cin(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i, input logic bad_s, input logic bad_g);
    logic [64:0] sum;
    sum      = vec_sum(i);
    a        = vec_a(i);
    b        = vec_b(i);
    cin      = vec_cin(i);
    s_ref    = sum[63:0];
    cout_ref = sum[64];
    prop_ref = &(vec_a(i) ^ vec_b(i));
    gen_ref  = sum[64];
    s_duv    = bad_s ? (sum[63:0] ^ 64'h1) : sum[63:0];
    cout_duv = cout_ref;
    prop_duv = prop_ref;
    gen_duv  = bad_g ? ~gen_ref : gen_ref;
    valid    = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [64:0] s3;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; cin = 1'b0;
    a = '0; b = '0; s_ref = '0; s_duv = '0;
    cout_ref = 1'b0; prop_ref = 1'b0; gen_ref = 1'b0;
    cout_duv = 1'b0; prop_duv = 1'b0; gen_duv = 1'b0;
    step(); step();

    check("rst_ready", 64'(ready[0]), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_pass", 64'(pass[0]), 64'd0);

    // Reset mid-run after 5 vectors, one of them failing
    rst_n = 1'b1;
    pulse_start();
    check("run_ready", 64'(ready[0]), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      apply(i, i == 2, 1'b0);
      step();
    end
    valid = 1'b0;
    step();
    check("mid_vec_cnt", 64'(vec_cnt[0]), 64'd5);
    check("mid_err", 64'(err[0]), 64'd1);
    check("mid_ff_a", ff_a[0], vec_a(2));
    rst_n = 1'b0;
    #1;
    check("arst_vec_cnt", 64'(vec_cnt[0]), 64'd0);
    check("arst_fail_cnt", 64'(fail_cnt[0]), 64'd0);
    check("arst_err", 64'(err[0]), 64'd0);
    check("arst_ff_a", ff_a[0], 64'd0);
    check("arst_ready", 64'(ready[0]), 64'd0);
    step();
    rst_n = 1'b1;
    apply(1, 1'b0, 1'b0);
    step(); step();
    valid = 1'b0;
    check("idle_ignore_vec", 64'(vec_cnt[0]), 64'd0);
    check("idle_ready", 64'(ready[0]), 64'd0);
    check("idle_done", 64'(done[0]), 64'd0);

    // Clean 8-vector run with end-of-run timing
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      apply(i, 1'b0, 1'b0);
      step();
    end
    check("last_acc_ready", 64'(ready[0]), 64'd0);
    check("last_acc_done", 64'(done[0]), 64'd0);
    check("last_acc_vec", 64'(vec_cnt[0]), 64'd7);
    valid = 1'b0;
    step();
    check("clean_done", 64'(done[0]), 64'd1);
    check("clean_vec_cnt", 64'(vec_cnt[0]), 64'd8);
    check("clean_fail_cnt", 64'(fail_cnt[0]), 64'd0);
    check("clean_pass", 64'(pass[0]), 64'd1);
    step();
    check("clean_vec_hold", 64'(vec_cnt[0]), 64'd8);

    // Sum fails on vectors 3 and 6; capture holds vector 3
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      apply(i, (i == 3) || (i == 6), 1'b0);
      step();
      if (i == 4) begin
        check("f3_fail_cnt", 64'(fail_cnt[0]), 64'd1);
        check("f3_err", 64'(err[0]), 64'd1);
      end
    end
    valid = 1'b0;
    step();
    s3 = vec_sum(3);
    check("f36_fail_cnt", 64'(fail_cnt[0]), 64'd2);
    check("f36_done", 64'(done[0]), 64'd1);
    check("f36_pass", 64'(pass[0]), 64'd0);
    check("f36_ff_a", ff_a[0], vec_a(3));
    check("f36_ff_b", ff_b[0], vec_b(3));
    check("f36_ff_cin", 64'(ff_cin[0]), 64'(vec_cin(3)));
    check("f36_ff_s_ref", ff_s_ref[0], s3[63:0]);
    check("f36_ff_s_duv", ff_s_duv[0], s3[63:0] ^ 64'h1);
    check("f36_halt_vec", 64'(vec_cnt[2]), 64'd3);

    // gen-only difference on vector 2: PG counts it, BASIC ignores it, stop-on-fail halts
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      apply(i, 1'b0, i == 2);
      step();
    end
    valid = 1'b0;
    step();
    check("pg_fail_cnt", 64'(fail_cnt[0]), 64'd1);
    check("pg_pass", 64'(pass[0]), 64'd0);
    check("basic_fail_cnt", 64'(fail_cnt[1]), 64'd0);
    check("basic_err", 64'(err[1]), 64'd0);
    check("basic_pass", 64'(pass[1]), 64'd1);
    check("halt_vec_cnt", 64'(vec_cnt[2]), 64'd2);
    check("halt_fail_cnt", 64'(fail_cnt[2]), 64'd1);
    check("halt_done", 64'(done[2]), 64'd1);
    check("halt_ready", 64'(ready[2]), 64'd0);
    check("halt_ff_a", ff_a[2], vec_a(2));

    // start together with valid in DONE: vector dropped, results cleared
    apply(1, 1'b1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b0;
    check("restart_vec_cnt", 64'(vec_cnt[0]), 64'd0);
    check("restart_fail_cnt", 64'(fail_cnt[0]), 64'd0);
    check("restart_err", 64'(err[0]), 64'd0);
    check("restart_ff_a", ff_a[0], 64'd0);
    check("restart_done", 64'(done[0]), 64'd0);
    check("restart_ready", 64'(ready[0]), 64'd1);
    step();
    check("restart_drop_vec", 64'(vec_cnt[0]), 64'd0);
    check("restart_drop_fail", 64'(fail_cnt[0]), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      apply(i + 10, 1'b0, 1'b0);
      step();
    end
    valid = 1'b0;
    step();
    check("rerun_vec_cnt", 64'(vec_cnt[0]), 64'd8);
    check("rerun_pass", 64'(pass[0]), 64'd1);
    check("rerun_halt_pass", 64'(pass[2]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
